// File: rtl/divider_pkg.sv
// Shared arithmetic constants: FSM state encoding and the default operand width.
package divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divider.sv
// Unsigned sequential divider by repeated subtraction with a start/busy/done handshake.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remn_q, remn_d;
    logic             dbz_q, dbz_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            quot_q  <= '0;
            remn_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            remn_q  <= remn_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        remn_d  = remn_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d = dividend;
                    dvs_d = divisor;
                    quo_d = '0;
                    // Zero divisor finishes immediately with a saturated quotient.
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remn_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_q >= dvs_q) begin
                    rem_d = rem_q - dvs_q;
                    quo_d = quo_q + 1'b1;
                end else begin
                    state_d = DONE;
                    quot_d  = quo_q;
                    remn_d  = rem_q;
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quot_q;
    assign remainder   = remn_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for the repeated-subtraction divider: results, latency, ignored starts, async reset.
module tb_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend, divisor;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero;

    int errors = 0;
    int checks = 0;
    int bcnt, dedge;

    divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one op; count busy cycles and edges from the accepted edge until done.
    // poke_at >= 0 pulses start with other operands at that edge and keeps changing inputs.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int poke_at,
                         output int nbusy, output int nedge);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0;
        nedge = 0;
        while (!done && nedge < 600) begin
            if (busy) nbusy++;
            if (poke_at >= 0 && nedge >= poke_at) begin
                start    = (nedge == poke_at);
                dividend = 8'd50 + nedge[7:0];
                divisor  = 8'd5;
            end
            @(posedge clk); #1;
            nedge++;
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [7:0] q, input logic [7:0] r,
                            input logic z, input int exp_busy, input int exp_edge);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".quotient"}, quotient, q);
        check({tag, ".remainder"}, remainder, r);
        check({tag, ".dbz"}, div_by_zero, z);
        check({tag, ".busy_cycles"}, bcnt, exp_busy);
        check({tag, ".done_edge"}, dedge, exp_edge);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".hold_q"}, quotient, q);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        check("rst.quotient", quotient, 0);
        check("rst.remainder", remainder, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dbz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'd100, 8'd7, -1, bcnt, dedge);
        check_op("100/7", 8'd14, 8'd2, 1'b0, 15, 15);

        do_op(8'd5, 8'd9, -1, bcnt, dedge);
        check_op("5/9", 8'd0, 8'd5, 1'b0, 1, 1);

        do_op(8'd0, 8'd3, -1, bcnt, dedge);
        check_op("0/3", 8'd0, 8'd0, 1'b0, 1, 1);

        do_op(8'd255, 8'd1, -1, bcnt, dedge);
        check_op("255/1", 8'd255, 8'd0, 1'b0, 256, 256);

        do_op(8'd200, 8'd0, -1, bcnt, dedge);
        check_op("200/0", 8'd255, 8'd200, 1'b1, 0, 0);

        do_op(8'd9, 8'd3, -1, bcnt, dedge);
        check_op("9/3", 8'd3, 8'd0, 1'b0, 4, 4);

        // Start pulse and input churn while busy must not disturb the result.
        do_op(8'd100, 8'd7, 3, bcnt, dedge);
        check_op("ignored", 8'd14, 8'd2, 1'b0, 15, 15);

        // Abort a long op with an asynchronous reset between edges.
        dividend = 8'd255; divisor = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #2;
        check("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.quotient", quotient, 0);
        check("abort.remainder", remainder, 0);
        check("abort.done", done, 0);
        check("abort.dbz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;
        bcnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) bcnt++;
        end
        check("abort.no_done", bcnt, 0);

        do_op(8'd10, 8'd3, -1, bcnt, dedge);
        check_op("10/3", 8'd3, 8'd1, 1'b0, 4, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
